ga_host_port: RTL and testbench

- Responder-side host interface for the fixed-point geometry accelerator.
- Decodes host commands on addr and collects 4-beat matrix/vertex blocks from data_in.
- Hands each collected block to the transform core via a start/done handshake, stores the core's 4x4 result, and returns it column by column on data_out.
- All elements are Q16.16 two's complement and are passed through unmodified.

---
 rtl/ga_host_port.sv | 152 +++++++++++++++
 tb/tb_ga_host_port.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ga_host_port.sv
// Host-side responder for the geometry accelerator: collects 4-beat blocks,
// hands them to the transform core and returns the stored 4x4 result by column.
module ga_host_port #(
    parameter logic [31:0] ADDR_MATRIX = 32'd0,
    parameter logic [31:0] ADDR_VRT    = 32'd1,
    parameter logic [31:0] ADDR_RSLT   = 32'd2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  addr,
    input  logic [127:0] data_in,
    output logic [127:0] data_out,
    output logic         rdy,
    output logic         op_start,
    output logic         op_sel,
    output logic [511:0] op_blk,
    input  logic         op_done,
    input  logic [511:0] op_res,
    output logic         err
);

    localparam int unsigned     CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_L0, S_L1, S_L2, S_L3, S_EXEC, S_R0, S_R1, S_R2, S_R3
    } state_t;

    state_t             state_q, state_d;
    logic               op_start_q, op_start_d;
    logic               op_sel_q, op_sel_d;
    logic [511:0]       op_blk_q, op_blk_d;
    logic [511:0]       res_q, res_d;
    logic [127:0]       data_out_q, data_out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    // Column c of the row-major store: element (r, c) sits at index 4r + c.
    function automatic logic [127:0] result_column(input logic [511:0] s, input int c);
        logic [127:0] col;
        col = '0;
        for (int r = 0; r < 4; r++) begin
            col[127-32*r -: 32] = s[511-32*(4*r+c) -: 32];
        end
        return col;
    endfunction

    always_comb begin
        // NOTE: every *_d takes its held value first so no path through this block infers a latch.
        state_d    = state_q;
        op_start_d = 1'b0;
        op_sel_d   = op_sel_q;
        op_blk_d   = op_blk_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        err_d      = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (addr == ADDR_MATRIX) begin
                    state_d  = S_L0;
                    op_sel_d = 1'b0;
                end else if (addr == ADDR_VRT) begin
                    state_d  = S_L0;
                    op_sel_d = 1'b1;
                end else if (addr == ADDR_RSLT) begin
                    state_d = S_R0;
                end
            end
            S_L0: begin
                op_blk_d[511 -: 128] = data_in;
                state_d              = S_L1;
            end
            S_L1: begin
                op_blk_d[383 -: 128] = data_in;
                state_d              = S_L2;
            end
            S_L2: begin
                op_blk_d[255 -: 128] = data_in;
                state_d              = S_L3;
            end
            S_L3: begin
                op_blk_d[127 -: 128] = data_in;
                state_d              = S_EXEC;
                op_start_d           = 1'b1;
                cnt_d                = '0;
            end
            S_EXEC: begin
                // A matrix compose leaves its result inside the core.
                if (op_done) begin
                    if (op_sel_q) res_d = op_res;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_R0:    state_d = S_R1;
            S_R1:    state_d = S_R2;
            S_R2:    state_d = S_R3;
            S_R3:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // data_out is registered from the next state so each column is stable for its whole cycle.
    always_comb begin
        data_out_d = '0;
        unique case (state_d)
            S_R0:    data_out_d = result_column(res_q, 0);
            S_R1:    data_out_d = result_column(res_q, 1);
            S_R2:    data_out_d = result_column(res_q, 2);
            S_R3:    data_out_d = result_column(res_q, 3);
            default: data_out_d = '0;
        endcase
    end

    // NOTE: the result store is reset too, so a read before any vertex op returns zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            op_start_q <= 1'b0;
            op_sel_q   <= 1'b0;
            op_blk_q   <= '0;
            res_q      <= '0;
            data_out_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q    <= state_d;
            op_start_q <= op_start_d;
            op_sel_q   <= op_sel_d;
            op_blk_q   <= op_blk_d;
            res_q      <= res_d;
            data_out_q <= data_out_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign rdy      = (state_q == S_IDLE);
    assign op_start = op_start_q;
    assign op_sel   = op_sel_q;
    assign op_blk   = op_blk_q;
    assign data_out = data_out_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ga_host_port.sv
// Directed bench for ga_host_port: a transaction-level model of the expected outputs
// is compared against the DUT on every falling edge, plus literal spot checks.
module tb_ga_host_port;

    localparam int          TO     = 8;
    localparam logic [31:0] C_MTX  = 32'd0;
    localparam logic [31:0] C_VRT  = 32'd1;
    localparam logic [31:0] C_RSLT = 32'd2;
    localparam logic [31:0] PARK   = 32'hDEAD_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic [127:0] data_in;
    logic [127:0] data_out;
    logic         rdy, op_start, op_sel, op_done, err;
    logic [511:0] op_blk, op_res;

    ga_host_port #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .data_out(data_out),
        .rdy(rdy), .op_start(op_start), .op_sel(op_sel), .op_blk(op_blk),
        .op_done(op_done), .op_res(op_res), .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: element arrays for the collected block and the result store, plus expected outputs.
    logic [31:0]  m_blk [16];
    logic [31:0]  m_res [16];
    logic         exp_rdy, exp_start, exp_sel, exp_err, in_exec, chk_en;
    logic [127:0] exp_dout;
    logic [127:0] seen_col [4];
    logic [511:0] res_a, res_b, junk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] blk_vec();
        logic [511:0] v;
        for (int e = 0; e < 16; e++) v[511-32*e -: 32] = m_blk[e];
        return v;
    endfunction

    function automatic logic [127:0] col_vec(input int c);
        logic [127:0] v;
        for (int j = 0; j < 4; j++) v[127-32*j -: 32] = m_res[4*j+c];
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("rdy", 512'(rdy), 512'(exp_rdy));
            check("op_start", 512'(op_start), 512'(exp_start));
            check("err", 512'(err), 512'(exp_err));
            check("data_out", 512'(data_out), 512'(exp_dout));
            check("op_blk", op_blk, blk_vec());
            if (in_exec) check("op_sel", 512'(op_sel), 512'(exp_sel));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int e = 0; e < 16; e++) begin
            m_blk[e] = '0;
            m_res[e] = '0;
        end
        exp_rdy   = 1'b1;
        exp_start = 1'b0;
        exp_sel   = 1'b0;
        exp_err   = 1'b0;
        exp_dout  = '0;
        in_exec   = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // done_at: EXEC cycle index (0 = op_start cycle) in which the core pulses op_done; -1 = never.
    task automatic load(input logic [31:0] cmd, input logic [127:0] b0, input logic [127:0] b1,
                        input logic [127:0] b2, input logic [127:0] b3,
                        input int done_at, input logic [511:0] res);
        logic [127:0] beats [4];
        beats = '{b0, b1, b2, b3};
        addr = cmd;
        tick();
        addr    = PARK;
        exp_rdy = 1'b0;
        for (int n = 0; n < 4; n++) begin
            data_in = beats[n];
            tick();
            for (int j = 0; j < 4; j++) m_blk[4*n+j] = beats[n][127-32*j -: 32];
        end
        data_in   = '0;
        exp_start = 1'b1;
        exp_sel   = (cmd == C_VRT);
        in_exec   = 1'b1;
        for (int k = 0; k < TO; k++) begin
            if (k == done_at) begin
                op_done = 1'b1;
                op_res  = res;
            end
            tick();
            op_done   = 1'b0;
            exp_start = 1'b0;
            if (k == done_at) begin
                if (cmd == C_VRT)
                    for (int e = 0; e < 16; e++) m_res[e] = res[511-32*e -: 32];
                in_exec = 1'b0;
                exp_rdy = 1'b1;
                break;
            end
            if (k == TO - 1) begin
                exp_err = 1'b1;
                in_exec = 1'b0;
                exp_rdy = 1'b1;
            end
        end
    endtask

    task automatic read(input bit keep);
        addr = C_RSLT;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (!keep) addr = PARK;
            exp_rdy  = 1'b0;
            exp_dout = col_vec(c);
            @(negedge clk);
            seen_col[c] = data_out;
        end
        tick();
        exp_rdy  = 1'b1;
        exp_dout = '0;
    endtask

    initial begin
        for (int e = 0; e < 16; e++) begin
            res_a[511-32*e -: 32] = 32'h1000_0000 + 32'(e);
            res_b[511-32*e -: 32] = 32'h0111_0000 * 32'(e + 1);
            junk[511-32*e -: 32]  = 32'hA5A5_0000 + 32'(e);
        end
        addr    = PARK;
        data_in = '0;
        op_done = 1'b0;
        op_res  = '0;
        rst     = 1'b0;
        clear_model();
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check("reset_rdy_lit", 512'(rdy), 512'(1'b1));
        check("reset_dout_lit", 512'(data_out), 512'(0));
        idle_cycles(2);

        // Illegal command code stays in IDLE.
        addr = 32'd455;
        idle_cycles(3);
        check("illegal_rdy_lit", 512'(rdy), 512'(1'b1));
        addr = PARK;
        read(1'b0);

        // Matrix load: result store must stay untouched.
        load(C_MTX, {32'h0001_0000, 32'h0, 32'h0, 32'h012C_0000},
             {32'h0, 32'h0001_0000, 32'h0, 32'h012C_0000},
             {32'h0, 32'h0, 32'hFFFF_FFFA, 32'h0},
             {32'h0, 32'h0, 32'h0, 32'h0001_0000}, 3, junk);
        check("mtx_blk_lit", op_blk,
              512'h00010000_00000000_00000000_012C0000_00000000_00010000_00000000_012C0000_00000000_00000000_FFFFFFFA_00000000_00000000_00000000_00000000_00010000);
        read(1'b0);

        // Vertex load, core answers in the 7th EXEC cycle; back-to-back reads with addr held.
        load(C_VRT, 128'h11111111_22222222_33333333_44444444, 128'h55555555_66666666_77777777_88888888,
             128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC, 128'hDDDDDDDD_EEEEEEEE_FFFFFFFF_00000001, 6, res_a);
        read(1'b1);
        read(1'b0);
        check("col0_lit", 512'(seen_col[0]), 512'(128'h10000000_10000004_10000008_1000000C));
        check("col1_lit", 512'(seen_col[1]), 512'(128'h10000001_10000005_10000009_1000000D));
        check("col3_lit", 512'(seen_col[3]), 512'(128'h10000003_10000007_1000000B_1000000F));

        // op_done outside EXEC is ignored.
        op_done = 1'b1;
        op_res  = junk;
        tick();
        op_done = 1'b0;
        read(1'b0);

        // op_done in the op_start cycle.
        load(C_VRT, 128'h1, 128'h2, 128'h3, 128'h4, 0, res_b);
        read(1'b0);

        // Reset in the middle of L2 abandons everything.
        addr = C_VRT;
        tick();
        addr    = PARK;
        exp_rdy = 1'b0;
        data_in = 128'hCAFE;
        tick();
        m_blk[3] = 32'hCAFE;
        data_in  = 128'hBEEF;
        tick();
        m_blk[7] = 32'hBEEF;
        @(negedge clk);
        #1 rst = 1'b0;
        clear_model();
        #1 check("async_rst_rdy_lit", 512'(rdy), 512'(1'b1));
        tick();
        rst     = 1'b1;
        data_in = '0;
        idle_cycles(3);
        read(1'b0);

        // op_done in the last allowed EXEC cycle wins over the timeout.
        load(C_VRT, 128'h5, 128'h6, 128'h7, 128'h8, TO - 1, res_a);
        check("late_done_err_lit", 512'(err), 512'(1'b0));
        read(1'b0);

        // Core never answers: sticky err, old result still readable.
        load(C_VRT, 128'h9, 128'hA, 128'hB, 128'hC, -1, res_b);
        check("timeout_err_lit", 512'(err), 512'(1'b1));
        check("timeout_rdy_lit", 512'(rdy), 512'(1'b1));
        read(1'b0);
        check("timeout_col0_lit", 512'(seen_col[0]), 512'(128'h10000000_10000004_10000008_1000000C));
        load(C_MTX, 128'hD, 128'hE, 128'hF, 128'h10, 2, junk);
        read(1'b0);
        load(C_VRT, 128'h11, 128'h12, 128'h13, 128'h14, 4, res_b);
        read(1'b0);
        check("err_sticky_lit", 512'(err), 512'(1'b1));
        idle_cycles(2);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
